// File: rtl/sr_bank_driver.sv
// sr_bank_driver: drives an SR flip-flop bank to a target word with readback and retry; optional power-up clear when SR_BANK_DRIVER_INIT_EN is defined
module sr_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int PULSE_CYC = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target,
  input  logic             load,
  output logic             ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             error
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, INIT} state_t;
  localparam logic [4:0] PLAST = 5'(PULSE_CYC - 1);
  localparam logic [4:0] PCYC  = 5'(PULSE_CYC);
  localparam logic [2:0] RMAX  = 3'(MAX_RETRY);
`ifdef SR_BANK_DRIVER_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] tgt, tgt_n, diff, diff_n, s_n, r_n, dnew, dchk;
  logic [4:0] pcnt, pcnt_n;
  logic [2:0] rcnt, rcnt_n;
  logic done_n, err_n;
  assign ready = state == IDLE;
  assign dnew  = target ^ q_fb;
  assign dchk  = tgt ^ q_fb;
  // next state and next registered outputs; s/r are derived from target and diff so set and reset never overlap
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    diff_n  = diff;
    pcnt_n  = pcnt;
    rcnt_n  = rcnt;
    s_n     = '0;
    r_n     = '0;
    done_n  = 1'b0;
    err_n   = error;
    case (state)
      IDLE: if (load) begin
        tgt_n   = target;
        diff_n  = dnew;
        rcnt_n  = '0;
        pcnt_n  = '0;
        err_n   = 1'b0;
        s_n     = target & dnew;
        r_n     = ~target & dnew;
        state_n = dnew != '0 ? DRIVE : SETTLE;
      end
      DRIVE: if (pcnt == PLAST) state_n = SETTLE;
      else begin
        pcnt_n = pcnt + 5'd1;
        s_n    = tgt & diff;
        r_n    = ~tgt & diff;
      end
      SETTLE: state_n = CHECK;
      CHECK: if (dchk == '0) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end else if (rcnt < RMAX) begin
        rcnt_n  = rcnt + 3'd1;
        diff_n  = dchk;
        pcnt_n  = '0;
        s_n     = tgt & dchk;
        r_n     = ~tgt & dchk;
        state_n = DRIVE;
      end else begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
      INIT: begin
        pcnt_n  = pcnt + 5'd1;
        r_n     = pcnt < PCYC ? '1 : '0;
        state_n = pcnt == PCYC ? IDLE : INIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset drops every drive immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      tgt   <= '0;
      diff  <= '0;
      pcnt  <= '0;
      rcnt  <= '0;
      s_out <= '0;
      r_out <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      diff  <= diff_n;
      pcnt  <= pcnt_n;
      rcnt  <= rcnt_n;
      s_out <= s_n;
      r_out <= r_n;
      done  <= done_n;
      error <= err_n;
    end
  end
endmodule

// File: tb/tb_sr_bank_driver.sv
// tb_sr_bank_driver: randomized self-checking bench for sr_bank_driver against an SR bank model
module tb_sr_bank_driver;
  localparam int P  = 3;
  localparam int MR = 2;
  logic clk = 0, rst_n = 0, load = 0, ready, done, error;
  logic [3:0] target = 0, s_out, r_out, q_fb;
  logic [3:0] bank = 0, stuck0 = 0, pre_val = 0, mq = 0;
  logic pre_en = 0;
  int ntest = 0, nfail = 0;

  sr_bank_driver #(.WIDTH(4), .PULSE_CYC(P), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .target(target), .load(load), .ready(ready),
    .s_out(s_out), .r_out(r_out), .q_fb(q_fb), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // srff bank: set wins nothing over reset because the driver never asserts both
  always @(posedge clk) bank <= pre_en ? pre_val : (bank | s_out) & ~r_out;
  assign q_fb = bank & ~stuck0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) check("sr_excl", {28'd0, s_out & r_out}, 0);

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, ready}, 1);
  endtask

  task automatic busy_chk(input logic [3:0] es, input logic [3:0] er);
    check("s_out", {28'd0, s_out}, {28'd0, es});
    check("r_out", {28'd0, r_out}, {28'd0, er});
    check("ready_busy", {31'd0, ready}, 0);
    check("done_busy", {31'd0, done}, 0);
    check("err_busy", {31'd0, error}, 0);
    target = 4'($urandom);
    load   = 1'($urandom);
    @(negedge clk);
  endtask

  // one transfer: model replays attempts as whole pulses on an abstract bank value
  task automatic xfer(input logic [3:0] tgt, input bit pre, input logic [3:0] pv, input logic [3:0] st);
    logic [3:0] d, fb;
    int att = 0;
    stuck0 = st;
    if (pre) begin
      pre_en = 1; pre_val = pv;
      @(negedge clk);
      pre_en = 0; mq = pv;
    end
    check("ready_idle", {31'd0, ready}, 1);
    target = tgt; load = 1;
    fb = mq & ~stuck0;
    @(negedge clk);
    forever begin
      d = tgt ^ fb;
      if (d != 0) begin
        repeat (P) busy_chk(tgt & d, ~tgt & d);
        mq = (mq & ~d) | (tgt & d);
        fb = mq & ~stuck0;
      end
      busy_chk(0, 0);
      busy_chk(0, 0);
      if (fb == tgt) begin
        check("done", {31'd0, done}, 1);
        check("err_ok", {31'd0, error}, 0);
        check("ready_done", {31'd0, ready}, 1);
        break;
      end
      if (att == MR) begin
        check("err", {31'd0, error}, 1);
        check("no_done", {31'd0, done}, 0);
        check("ready_err", {31'd0, ready}, 1);
        break;
      end
      att++;
    end
    load = 0;
  endtask

  initial begin
    #3;
    check("rst_s", {28'd0, s_out}, 0);
    check("rst_r", {28'd0, r_out}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, error}, 0);
`ifndef SR_BANK_DRIVER_INIT_EN
    check("rst_ready", {31'd0, ready}, 1);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    wait_ready();
    xfer(4'b1010, 1, 4'b0000, 0);
    check("qfb_1010", {28'd0, q_fb}, 32'hA);
    xfer(4'b0110, 1, 4'b1100, 0);
    xfer(4'b0101, 1, 4'b0101, 0);
    xfer(4'b0001, 1, 4'b0000, 4'b0001);
    repeat (2) begin
      @(negedge clk);
      check("err_sticky", {31'd0, error}, 1);
    end
    xfer(4'b0011, 1, 4'b0000, 0);
    stuck0 = 0; pre_en = 1; pre_val = 0;
    @(negedge clk);
    pre_en = 0;
    target = 4'b1111; load = 1;
    @(negedge clk);
    load = 0;
    check("mid_s", {28'd0, s_out}, 32'hF);
    #2 rst_n = 0;
    #1;
    check("mid_rst_s", {28'd0, s_out}, 0);
    check("mid_rst_r", {28'd0, r_out}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_err", {31'd0, error}, 0);
`ifndef SR_BANK_DRIVER_INIT_EN
    check("mid_rst_ready", {31'd0, ready}, 1);
`endif
    @(negedge clk);
    rst_n = 1;
`ifdef SR_BANK_DRIVER_INIT_EN
    repeat (P) begin
      @(negedge clk);
      check("init_r", {28'd0, r_out}, 32'hF);
      check("init_s", {28'd0, s_out}, 0);
      check("init_ready", {31'd0, ready}, 0);
    end
`endif
    wait_ready();
    xfer(4'($urandom), 1, 4'($urandom), 0);
    for (int i = 0; i < 40; i++)
      xfer(4'($urandom), $urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'd0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
